// File: rtl/he_wb_host.sv
// Wishbone classic-cycle initiator for the HE accelerator slave port.
// Turns valid/ready commands into single bus cycles and returns one response each.
module he_wb_host #(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          ADDR_WIDTH      = 9,
    parameter int          WORD_ADDR_WIDTH = 8,
    parameter int          TIMEOUT         = 16,
    parameter int          SETTLE_CYCLES   = 12
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_kind,
    input  logic [WORD_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                cmd_wdata,
    input  logic [1:0]                 cmd_op,
    input  logic [ADDR_WIDTH-1:0]      cmd_src_a,
    input  logic [ADDR_WIDTH-1:0]      cmd_src_b,
    input  logic [ADDR_WIDTH-1:0]      cmd_dst,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,

    output logic                       wbm_cyc_o,
    output logic                       wbm_stb_o,
    output logic                       wbm_we_o,
    output logic [3:0]                 wbm_sel_o,
    output logic [31:0]                wbm_adr_o,
    output logic [31:0]                wbm_dat_o,
    input  logic [31:0]                wbm_dat_i,
    input  logic                       wbm_ack_i
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // BUS    | Wishbone cycle in flight, timeout counter running
    // SETTLE | opcode written, waiting for the accelerator to finish
    // RESP   | response presented until rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] KIND_WR  = 2'b00;
    localparam logic [1:0] KIND_RD  = 2'b01;
    localparam logic [1:0] KIND_OP  = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES != 0);

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_is_op;
    logic [7:0]  r_tmo_cnt;
    logic [7:0]  r_settle_cnt;

    logic [31:0] w_rw_addr;
    logic [31:0] w_op_word;

    assign w_rw_addr = BASE_ADDR + 32'({cmd_addr, 2'b00});

    // Opcode word: valid flag in bit 31, then dst/src_b/src_a/op packed from the LSB.
    always_comb begin
        w_op_word                                   = '0;
        w_op_word[31]                               = 1'b1;
        w_op_word[1:0]                              = cmd_op;
        w_op_word[2 +: ADDR_WIDTH]                  = cmd_src_a;
        w_op_word[2 + ADDR_WIDTH +: ADDR_WIDTH]     = cmd_src_b;
        w_op_word[2 + 2*ADDR_WIDTH +: ADDR_WIDTH]   = cmd_dst;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_is_op      <= 1'b0;
            r_tmo_cnt    <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        if (cmd_kind == KIND_RSV) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cyc     <= 1'b1;
                            r_stb     <= 1'b1;
                            r_sel     <= 4'hF;
                            r_we      <= (cmd_kind != KIND_RD);
                            r_is_op   <= (cmd_kind == KIND_OP);
                            r_tmo_cnt <= '0;
                            if (cmd_kind == KIND_OP) begin
                                r_adr <= BASE_ADDR;
                                r_dat <= w_op_word;
                            end else begin
                                r_adr <= w_rw_addr;
                                r_dat <= (cmd_kind == KIND_WR) ? cmd_wdata : 32'd0;
                            end
                            r_state <= ST_BUS;
                        end
                    end
                end

                ST_BUS: begin
                    if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= '0;
                        if (!r_we) begin
                            r_rsp_rdata <= wbm_dat_i;
                        end
                        if (r_is_op && HAS_SETTLE) begin
                            r_settle_cnt <= SETTLE_INIT;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        // Slave never answered: abandon the cycle and skip settling.
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_sel       <= '0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end

                ST_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_he_wb_host.sv
// Scoreboard bench for he_wb_host: stimulus pushes expectations, a negedge monitor
// checks bus cycles and responses against a word-level memory model.
module tb_he_wb_host;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam int          AW     = 9;
    localparam int          WAW    = 8;
    localparam int          TMO    = 16;
    localparam int          SETTLE = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [WAW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src_a;
    logic [AW-1:0] cmd_src_b;
    logic [AW-1:0] cmd_dst;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_o;
    logic [31:0]   wbm_dat_i = 32'd0;
    logic          wbm_ack_i = 1'b0;

    he_wb_host #(
        .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .WORD_ADDR_WIDTH(WAW),
        .TIMEOUT(TMO), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        chk_dat;
        int          cycles;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_exp_t;

    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] slv_mem [bit [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_num = 0;

    int s_ack_at  = 1;
    bit s_noack   = 1'b0;
    int s_cnt     = 0;
    bit force_ack = 1'b0;
    bit stray_en  = 1'b0;
    bit bp_rand   = 1'b0;
    int hold_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc_num);
        end
    endtask

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] op_word(input logic [1:0] op, input logic [AW-1:0] a,
                                            input logic [AW-1:0] b, input logic [AW-1:0] d);
        return 32'h8000_0000 | (32'(d) << (2 + 2*AW)) | (32'(b) << (2 + AW))
             | (32'(a) << 2) | 32'(op);
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return seed_val(BASE + 32'(w) * 32'd4);
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        ref_mem[w] = v;
        slv_mem[BASE + 32'(w) * 32'd4] = v;
    endtask

    always @(posedge clk) cyc_num <= cyc_num + 1;

    // Wishbone slave: acks on the s_ack_at-th strobe cycle, optional stray acks when idle.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            s_cnt     = 0;
            wbm_ack_i = force_ack;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            s_cnt++;
            if (!s_noack && s_cnt == s_ack_at) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) slv_mem[wbm_adr_o] = wbm_dat_o;
                else wbm_dat_i = slv_mem.exists(wbm_adr_o) ? slv_mem[wbm_adr_o] : seed_val(wbm_adr_o);
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
        end else begin
            s_cnt     = 0;
            wbm_ack_i = force_ack | ((stray_en || hold_cnt > 0) && ($urandom_range(0, 1) == 1));
            wbm_dat_i = $urandom;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) hold_cnt--;
        end else if (bp_rand) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end else begin
            rsp_ready = 1'b1;
        end
    end

    // Monitor
    bus_exp_t    cur;
    bit          have_cur   = 1'b0;
    bit          in_cyc     = 1'b0;
    int          cyc_len    = 0;
    int          last_bus   = 0;
    bit          prev_valid = 1'b0;
    bit          held       = 1'b0;
    logic [31:0] h_rdata;
    logic        h_err;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_cyc = 0; have_cur = 0; prev_valid = 0; held = 0;
        end else begin
            if (wbm_cyc_o || wbm_stb_o) begin
                if (!in_cyc) begin
                    in_cyc  = 1;
                    cyc_len = 0;
                    if (bus_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL bus_unexpected: got cycle at 0x%0h, want none", wbm_adr_o);
                    end else begin
                        cur      = bus_q.pop_front();
                        have_cur = 1;
                    end
                end
                cyc_len++;
                last_bus = cyc_num;
                if (have_cur) begin
                    chk("bus_cyc_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'(2'b11));
                    chk("bus_adr", 64'(wbm_adr_o), 64'(cur.adr));
                    chk("bus_we", 64'(wbm_we_o), 64'(cur.we));
                    chk("bus_sel", 64'(wbm_sel_o), 64'(4'hF));
                    if (cur.chk_dat) chk("bus_dat", 64'(wbm_dat_o), 64'(cur.dat));
                end
            end else if (in_cyc) begin
                in_cyc = 0;
                if (have_cur) chk("bus_len", 64'(cyc_len), 64'(cur.cycles));
                have_cur = 0;
            end

            if (rsp_valid) begin
                if (!prev_valid) begin
                    if (rsp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL rsp_unexpected: got response 0x%0h, want none", rsp_rdata);
                    end else if (rsp_q[0].lat >= 0) begin
                        chk("rsp_latency", 64'(cyc_num - last_bus), 64'(rsp_q[0].lat));
                    end
                end else if (held) begin
                    chk("hold_rdata", 64'(rsp_rdata), 64'(h_rdata));
                    chk("hold_err", 64'(rsp_err), 64'(h_err));
                end
                chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                chk("bus_idle_in_resp", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
                if (rsp_ready) begin
                    held = 0;
                    if (rsp_q.size() != 0) begin
                        rsp_exp_t e;
                        e = rsp_q.pop_front();
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                end else begin
                    held    = 1;
                    h_rdata = rsp_rdata;
                    h_err   = rsp_err;
                end
            end else begin
                held = 0;
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic issue(input logic [1:0] kind, input logic [WAW-1:0] addr,
                         input logic [31:0] wd, input logic [1:0] op,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input int ack_at, input bit noack);
        bus_exp_t    be;
        rsp_exp_t    re;
        logic [31:0] rw_adr;
        int          guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_ready_wait: got %b, want 1 within 400 cycles", cmd_ready);
            return;
        end
        s_ack_at = ack_at;
        s_noack  = noack;
        rw_adr   = BASE + 32'(addr) * 32'd4;
        be.cycles = noack ? TMO : ack_at;
        case (kind)
            2'b00: begin
                be.adr = rw_adr; be.dat = wd; be.we = 1'b1; be.chk_dat = 1'b1;
                re = '{32'd0, noack, 1};
                if (!noack) ref_mem[int'(addr)] = wd;
            end
            2'b01: begin
                be.adr = rw_adr; be.dat = 32'd0; be.we = 1'b0; be.chk_dat = 1'b0;
                re = '{noack ? 32'd0 : ref_read(int'(addr)), noack, 1};
            end
            2'b10: begin
                be.adr = BASE; be.dat = op_word(op, a, b, d); be.we = 1'b1; be.chk_dat = 1'b1;
                re = '{32'd0, noack, noack ? 1 : 1 + SETTLE};
                if (!noack) ref_mem[0] = be.dat;
            end
            default: begin
                re = '{32'd0, 1'b1, -1};
            end
        endcase
        if (kind != 2'b11) bus_q.push_back(be);
        rsp_q.push_back(re);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_kind  = 2'($urandom);
        cmd_addr  = WAW'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || cmd_ready !== 1'b1) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
        chk("drain_bus_q", 64'(bus_q.size()), 64'd0);
    endtask

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_kind  = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_op    = '0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_dst   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        chk("reset_bus_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'd0);
        chk("reset_bus_data", {wbm_adr_o, wbm_dat_o}, 64'd0);
        @(posedge clk);
        #1;

        // Directed scenarios
        issue(2'b00, 8'd1, 32'd10, 2'b00, 9'd0, 9'd0, 9'd0, 2, 1'b0);
        issue(2'b10, 8'd0, 32'd0, 2'b10, 9'd0, 9'd100, 9'd50, 1, 1'b0);
        preload(51, 32'd30);
        issue(2'b01, 8'd51, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 3, 1'b0);
        issue(2'b01, 8'd9, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 1, 1'b1);
        issue(2'b00, 8'd9, 32'hCAFE_F00D, 2'b00, 9'd0, 9'd0, 9'd0, 1, 1'b0);
        issue(2'b01, 8'd9, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 4, 1'b0);
        drain();
        preload(20, 32'd695);
        issue(2'b01, 8'd20, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 2, 1'b0);
        hold_cnt = 5;
        issue(2'b11, 8'd3, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 1, 1'b0);
        issue(2'b00, 8'd255, 32'h1234_5678, 2'b00, 9'd0, 9'd0, 9'd0, 1, 1'b0);
        issue(2'b10, 8'd0, 32'd0, 2'b11, 9'd511, 9'd511, 9'd511, 2, 1'b1);
        drain();

        // Randomized traffic with backpressure and stray acks
        bp_rand  = 1'b1;
        stray_en = 1'b1;
        repeat (60) begin
            logic [1:0] k;
            k = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(k, 8'($urandom_range(0, 31)), $urandom, 2'($urandom), AW'($urandom),
                  AW'($urandom), AW'($urandom), $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
        end
        bp_rand  = 1'b0;
        stray_en = 1'b0;
        drain();

        // Reset in the middle of a bus cycle
        issue(2'b01, 8'd7, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 6, 1'b0);
        guard = 0;
        while (wbm_cyc_o !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rst_test_in_bus", 64'(wbm_cyc_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        #1;
        chk("rst_async_cyc_stb_we", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
        force_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("post_rst_idle", 64'({rsp_valid, wbm_cyc_o, wbm_stb_o}), 64'd0);
        end
        force_ack = 1'b0;
        @(posedge clk);
        #1;
        issue(2'b00, 8'd7, 32'hA5A5_0707, 2'b00, 9'd0, 9'd0, 9'd0, 1, 1'b0);
        issue(2'b01, 8'd7, 32'd0, 2'b00, 9'd0, 9'd0, 9'd0, 2, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/he_wb_host.md
Name: he_wb_host

Overview:
- Wishbone classic-cycle initiator that drives the homomorphic-encryption accelerator's slave port: word loads, opcode issue and result readback.
- Replaces hand-sequenced stb/cyc toggling with a command/response valid-ready interface.
- Sits between a host-side controller (or bench sequencer) and the accelerator's wbs_* port.
- Adds a post-opcode settle delay, because the accelerator exposes no completion flag.

Parameters:
- BASE_ADDR, 32'h30000000, accelerator base; also the opcode register address.
- ADDR_WIDTH, 9, width of the operand/destination fields in the opcode word.
- WORD_ADDR_WIDTH, 8, width of cmd_addr (word offset from BASE_ADDR).
- TIMEOUT, 16, maximum cycles stb may stay high without an ack (range 1..255).
- SETTLE_CYCLES, 12, idle cycles inserted after an opcode write completes (range 0..255).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_kind  in  2  00 write word, 01 read word, 10 issue opcode, 11 reserved.
- cmd_addr  in  WORD_ADDR_WIDTH  word offset for read/write.
- cmd_wdata  in  32  write data.
- cmd_op  in  2  opcode: 00 encrypt, 01 decrypt, 10 add, 11 multiply.
- cmd_src_a  in  ADDR_WIDTH  operand A location.
- cmd_src_b  in  ADDR_WIDTH  operand B location.
- cmd_dst  in  ADDR_WIDTH  result location.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for write/opcode/timeout.
- rsp_err  out  1  bus timeout occurred.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select; always 4'b1111 during a cycle.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready=1; counters 0.
- FSM states: IDLE, BUS, SETTLE, RESP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On valid&ready with kind 11: go to RESP with rsp_err=1 and no bus cycle.
  - On any other kind: register the command and enter BUS next cycle.
- Address generation:
  - Write/read: wbm_adr_o = BASE_ADDR + {cmd_addr, 2'b00}, 32-bit unsigned add, carry discarded.
  - Opcode: wbm_adr_o = BASE_ADDR.
- Opcode data:
  - [1:0]=cmd_op, [2+AW-1:2]=src_a, [2+2AW-1:2+AW]=src_b, [2+3AW-1:2+2AW]=dst, where AW=ADDR_WIDTH.
  - Bit 31=1; all other bits 0.
  - With AW=9 the fields sit at [10:2], [19:11], [28:20].
- BUS:
  - cyc=stb=1 and sel=4'hF from the first BUS cycle; we=1 for write/opcode, 0 for read.
  - adr/dat_o stay stable for the whole cycle.
  - The ack is sampled on the rising edge. In the cycle after the ack is sampled, cyc/stb are 0.
  - Read data is captured on the ack edge.
  - Ack outcome: opcode goes to SETTLE; everything else goes to RESP.
  - Timeout counter starts at 0 on BUS entry and increments each BUS cycle without an ack.
  - When the count reaches TIMEOUT (ack still low on that edge): drop cyc/stb, set rsp_err=1, rsp_rdata=0, go to RESP without settling.
  - Ack and timeout on the same edge: the ack wins.
- SETTLE: bus idle; count SETTLE_CYCLES cycles, then RESP. SETTLE_CYCLES=0 goes directly to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle, return to IDLE.
  - Next command is accepted no earlier than the cycle after the handshake.
- Stray wbm_ack_i outside BUS: ignored, with no state change.
- One outstanding command at a time; no pipelining.
- Reset mid-operation: cyc/stb/we drop immediately (asynchronously); the in-flight command and response are discarded.

Test Plan:
- Write: kind=00, addr=1, wdata=10; slave acks on the 2nd BUS cycle -> adr=0x30000004, dat_o=10, we=1, sel=F for exactly 2 cycles; rsp_valid with err=0, rdata=0.
- Opcode ADD: op=10, a=0, b=100, dst=50 -> adr=0x30000000, dat_o=0x83232002.
  - After the ack, cyc stays low and rsp_valid stays low for 12 cycles, then rsp_valid=1.
- Read: kind=01, addr=51, slave returns 30 -> adr=0x300000CC, we=0; rsp_rdata=30, err=0.
- Timeout: read with ack tied low -> stb high exactly 16 cycles then low; rsp_err=1, rdata=0; a subsequent write completes normally.
- Backpressure: rsp_ready low for 5 cycles after the read of 695 -> rsp_valid/rdata stable at 695, cmd_ready=0, no bus activity.
  - Stray ack pulses during the hold change nothing.
- Reset in BUS: assert wb_rst_ni low mid-cycle -> cyc/stb/we go 0 in the same timestep.
  - After release: cmd_ready=1, rsp_valid=0; the stale ack is ignored.
